axi4_lite_master_bridge: RTL and testbench

//  Upstream driver for the AXI4-Lite register-bank slave.

---
 rtl/axi4_lite_pkg.sv | 29 ++
 rtl/axi4_lite_master_bridge.sv | 178 +++++++++++++++++
 tb/tb_axi4_lite_master_bridge.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite master bridge: response codes and FSM states.
// Pure declarations; no latency of its own.
// No backpressure; consumers own all flow control.
package axi4_lite_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    RSP
  } mst_state_t;

  // Word alignment test on the two byte-lane bits of an address.
  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/axi4_lite_master_bridge.sv
// Turns one local read/write command into a single AXI4-Lite transaction and returns the result.
// Latency with a zero-wait slave: response valid 3 cycles after the command cycle; misaligned: 1 cycle.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready; AXI VALIDs held until READY.
module axi4_lite_master_bridge #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = axi4_lite_pkg::DATA_W,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                ARESETN,
  // local command port
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  // local response port
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                timeout_err,
  // write address channel
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                AWVALID,
  input  logic                AWREADY,
  // write data channel
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WVALID,
  input  logic                WREADY,
  // write response channel
  input  logic                BVALID,
  input  logic [1:0]          BRESP,
  output logic                BREADY,
  // read address channel
  output logic [ADDR_W-1:0]   ARADDR,
  output logic                ARVALID,
  input  logic                ARREADY,
  // read data channel
  input  logic                RVALID,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  output logic                RREADY
);
  import axi4_lite_pkg::*;

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  mst_state_t       state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             aw_fin;
  logic             w_fin;
  logic             chan_wait;
  logic             chan_leave;

  assign cmd_ready = (state == IDLE);

  // A channel counts as finished once its VALID has already dropped or it handshakes this cycle.
  assign aw_fin = !AWVALID || AWREADY;
  assign w_fin  = !WVALID  || WREADY;

  // Identify states waiting on the AXI slave and the cycle in which each one completes.
  always_comb begin
    chan_wait  = 1'b0;
    chan_leave = 1'b0;
    case (state)
      WR_AW_W: begin chan_wait = 1'b1; chan_leave = aw_fin && w_fin;     end
      WR_B:    begin chan_wait = 1'b1; chan_leave = BVALID && BREADY;   end
      RD_AR:   begin chan_wait = 1'b1; chan_leave = ARVALID && ARREADY; end
      RD_R:    begin chan_wait = 1'b1; chan_leave = RVALID && RREADY;   end
      default: begin chan_wait = 1'b0; chan_leave = 1'b0;               end
    endcase
  end

  // Per-state wait counter; flags a stuck slave but never aborts the pending handshake.
  always_ff @(posedge clk or negedge ARESETN) begin
    if (!ARESETN) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else if (!chan_wait || chan_leave) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt == TMO_LAST) begin
      timeout_err <= 1'b1;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Transaction FSM with every AXI and response output registered.
  always_ff @(posedge clk or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= IDLE;
      AWADDR    <= '0;
      AWVALID   <= 1'b0;
      WDATA     <= '0;
      WSTRB     <= '0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARADDR    <= '0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            rsp_write <= cmd_write;
            rsp_rdata <= '0;
            rsp_resp  <= OKAY;
            if (!is_aligned(cmd_addr[1:0])) begin
              // Misaligned: answer locally, the slave never sees it.
              rsp_resp  <= SLVERR;
              rsp_valid <= 1'b1;
              state     <= RSP;
            end else if (cmd_write) begin
              AWADDR  <= cmd_addr;
              WDATA   <= cmd_wdata;
              WSTRB   <= '1;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              state   <= WR_AW_W;
            end else begin
              ARADDR  <= cmd_addr;
              ARVALID <= 1'b1;
              state   <= RD_AR;
            end
          end
        end
        WR_AW_W: begin
          if (AWVALID && AWREADY) AWVALID <= 1'b0;
          if (WVALID && WREADY)   WVALID  <= 1'b0;
          if (aw_fin && w_fin) begin
            BREADY <= 1'b1;
            state  <= WR_B;
          end
        end
        WR_B: begin
          if (BVALID) begin
            rsp_resp  <= BRESP;
            BREADY    <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        RD_AR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= RD_R;
          end
        end
        RD_R: begin
          if (RVALID) begin
            rsp_rdata <= RDATA;
            rsp_resp  <= RRESP;
            RREADY    <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Randomized bench: a register-bank AXI4-Lite slave plus a command-level reference model.
// Directed cases cover latency, stalls, misalignment, timeout and mid-transaction reset.
// Slave readiness and response delays are randomized in the final phase.
module tb_axi4_lite_master_bridge;

  logic        clk = 1'b0;
  logic        ARESETN;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        timeout_err;
  logic [7:0]  AWADDR, ARADDR;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  always #5 clk = ~clk;

  axi4_lite_master_bridge #(.ADDR_W(8), .DATA_W(32), .TIMEOUT_CYC(256)) dut (
    .clk(clk), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout_err(timeout_err),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY)
  );

  int vectors = 0, miscompares = 0;
  int cyc = 0, prot_err = 0;

  logic [31:0] slv_mem [64];
  logic [31:0] ref_mem [64];

  // slave knobs and state
  bit          rnd_rdy = 0;
  int          aw_stall = 0, w_stall = 0, ar_stall = 0, b_stall = 0;
  logic [1:0]  bresp_sel = 2'b00, rresp_sel = 2'b00;
  bit          aw_got = 0, w_got = 0, b_arm = 0, r_arm = 0;
  int          b_wait = 0, r_wait = 0;
  logic [7:0]  aw_a, ar_a;
  logic [31:0] w_d;
  logic [3:0]  w_s;

  // per-command observations
  int          n_aw, n_w, n_ar, n_b, cnt_awv, cnt_wv, c_cmd, last_lat;
  logic [7:0]  rec_awaddr, rec_araddr;
  logic [31:0] rec_wdata, last_rdata;
  logic [3:0]  rec_wstrb;
  logic [1:0]  last_resp;
  logic        last_write;
  bit          cmd_seen, rsp_done, ar_watch = 0;
  logic        err_250, arv_250, err_262, arv_262;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic next_ready(inout int stall, input logic vld);
    if (stall > 0) begin
      if (vld) stall--;
      return 1'b0;
    end
    return rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // One clock: note the handshakes set up for the coming edge, then at the
  // following falling edge check protocol rules and advance the slave.
  task automatic cycle();
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, c_hs, p_hs, aw_p, w_p, ar_p, rs_p;
    logic [7:0] awa, ara; logic [31:0] wd, rd; logic [3:0] ws; logic [1:0] rr; logic rw;
    aw_hs = AWVALID && AWREADY; w_hs = WVALID && WREADY; b_hs = BVALID && BREADY;
    ar_hs = ARVALID && ARREADY; r_hs = RVALID && RREADY;
    c_hs = cmd_valid && cmd_ready; p_hs = rsp_valid && rsp_ready;
    aw_p = AWVALID && !AWREADY; w_p = WVALID && !WREADY; ar_p = ARVALID && !ARREADY;
    rs_p = rsp_valid && !rsp_ready;
    awa = AWADDR; ara = ARADDR; wd = WDATA; ws = WSTRB; rd = rsp_rdata; rr = rsp_resp; rw = rsp_write;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (aw_p && (!AWVALID || AWADDR !== awa)) prot_err++;
    if (w_p && (!WVALID || WDATA !== wd || WSTRB !== ws)) prot_err++;
    if (ar_p && (!ARVALID || ARADDR !== ara)) prot_err++;
    if (rs_p && (!rsp_valid || rsp_rdata !== rd || rsp_resp !== rr || rsp_write !== rw)) prot_err++;
    if ((aw_hs && AWVALID) || (w_hs && WVALID) || (ar_hs && ARVALID)) prot_err++;
    if ((b_hs && BREADY) || (r_hs && RREADY)) prot_err++;
    if (AWVALID) cnt_awv++;
    if (WVALID) cnt_wv++;
    if (c_hs) begin c_cmd = cyc; cmd_seen = 1; end
    if (p_hs) rsp_done = 1;
    if (ar_watch && cmd_seen && cyc - c_cmd == 250) begin err_250 = timeout_err; arv_250 = ARVALID; end
    if (ar_watch && cmd_seen && cyc - c_cmd == 262) begin err_262 = timeout_err; arv_262 = ARVALID; end
    // slave channel reactions
    if (aw_hs) begin n_aw++; rec_awaddr = awa; aw_a = awa; aw_got = 1; end
    if (w_hs) begin n_w++; rec_wdata = wd; rec_wstrb = ws; w_d = wd; w_s = ws; w_got = 1; end
    if (b_hs) begin BVALID = 1'b0; n_b++; end
    if (r_hs) RVALID = 1'b0;
    if (ar_hs) begin
      n_ar++; rec_araddr = ara; ar_a = ara; r_arm = 1;
      r_wait = rnd_rdy ? $urandom_range(0, 3) : 0;
    end
    if (aw_got && w_got && !b_arm && !BVALID) begin
      for (int i = 0; i < 4; i++) if (w_s[i]) slv_mem[aw_a[7:2]][i*8 +: 8] = w_d[i*8 +: 8];
      b_arm = 1; aw_got = 0; w_got = 0;
      b_wait = (b_stall > 0) ? b_stall : (rnd_rdy ? $urandom_range(0, 3) : 0);
      b_stall = 0;
    end
    if (b_arm) begin
      if (b_wait == 0) begin BVALID = 1'b1; BRESP = bresp_sel; b_arm = 0; end
      else b_wait--;
    end
    if (r_arm) begin
      if (r_wait == 0) begin RVALID = 1'b1; RDATA = slv_mem[ar_a[7:2]]; RRESP = rresp_sel; r_arm = 0; end
      else r_wait--;
    end
    AWREADY = next_ready(aw_stall, AWVALID);
    WREADY  = next_ready(w_stall, WVALID);
    ARREADY = next_ready(ar_stall, ARVALID);
  endtask

  // Issue a command, predict the response at command level, and consume it.
  task automatic run_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d, input int rsp_delay);
    logic [31:0] exp_rd; logic [1:0] exp_resp; int exp_aw, exp_ar;
    n_aw = 0; n_w = 0; n_ar = 0; n_b = 0; cnt_awv = 0; cnt_wv = 0;
    cmd_seen = 0; rsp_done = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 1000 && !cmd_seen; i++) cycle();
    cmd_valid = 1'b0;
    chk("cmd_accept", cmd_seen, 1);
    for (int i = 0; i < 2000 && !rsp_valid; i++) cycle();
    chk("rsp_arrive", rsp_valid, 1);
    last_lat = cyc - c_cmd + 1;
    last_rdata = rsp_rdata; last_resp = rsp_resp; last_write = rsp_write;
    if (a[1:0] != 2'b00) begin
      exp_resp = 2'b10; exp_rd = 32'h0; exp_aw = 0; exp_ar = 0;
    end else if (wr) begin
      ref_mem[a[7:2]] = d;
      exp_resp = bresp_sel; exp_rd = 32'h0; exp_aw = 1; exp_ar = 0;
    end else begin
      exp_resp = rresp_sel; exp_rd = ref_mem[a[7:2]]; exp_aw = 0; exp_ar = 1;
    end
    chk("rsp_write", last_write, wr);
    chk("rsp_rdata", last_rdata, exp_rd);
    chk("rsp_resp", last_resp, exp_resp);
    chk("aw_count", n_aw, exp_aw);
    chk("w_count", n_w, exp_aw);
    chk("ar_count", n_ar, exp_ar);
    if (exp_aw == 1) begin
      chk("awaddr", rec_awaddr, a);
      chk("wdata", rec_wdata, d);
      chk("wstrb", rec_wstrb, 4'hF);
    end
    if (exp_ar == 1) chk("araddr", rec_araddr, a);
    for (int i = 0; i < rsp_delay; i++) cycle();
    rsp_ready = 1'b1;
    for (int i = 0; i < 100 && !rsp_done; i++) cycle();
    rsp_ready = 1'b0;
    chk("rsp_taken", rsp_done, 1);
    chk("idle_after_rsp", {cmd_ready, rsp_valid}, 2'b10);
  endtask

  initial begin
    logic [7:0] a;
    for (int i = 0; i < 64; i++) begin slv_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    ARESETN = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h0; cmd_wdata = 32'h0;
    rsp_ready = 1'b0; AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
    BVALID = 1'b0; BRESP = 2'b00; RVALID = 1'b0; RDATA = 32'h0; RRESP = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_axi_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 5'b0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", {rsp_write, rsp_rdata, rsp_resp}, 35'h0);
    chk("rst_timeout", timeout_err, 0);
    ARESETN = 1'b1;
    #1 chk("rst_cmd_ready", cmd_ready, 1);
    repeat (2) cycle();

    // 1: aligned write, slave always ready, OKAY
    run_cmd(1'b1, 8'h08, 32'hDEADBEEF, 0);
    chk("t1_latency", last_lat, 3);

    // 2: read back the same register
    run_cmd(1'b0, 8'h08, 32'h0, 1);
    chk("t2_rdata", last_rdata, 32'hDEADBEEF);

    // 3: AWREADY held off for three cycles of AWVALID
    aw_stall = 3;
    run_cmd(1'b1, 8'h10, 32'h1234_5678, 0);
    chk("t3_awvalid_cycles", cnt_awv, 4);
    chk("t3_wvalid_cycles", cnt_wv, 1);
    chk("t3_single_b", n_b, 1);

    // 4: misaligned read answers locally on the edge that takes the command
    run_cmd(1'b0, 8'h06, 32'h0, 0);
    chk("t4_latency", last_lat, 1);

    // 5: ARREADY stalled long enough to trip the timeout
    ar_stall = 300; ar_watch = 1;
    run_cmd(1'b0, 8'h08, 32'h0, 0);
    ar_watch = 0;
    chk("t5_err_before", err_250, 0);
    chk("t5_arvalid_250", arv_250, 1);
    chk("t5_err_after", err_262, 1);
    chk("t5_arvalid_262", arv_262, 1);
    chk("t5_err_sticky", timeout_err, 1);

    // 6: reset while waiting for B, response port not draining
    b_stall = 20; cmd_seen = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h20; cmd_wdata = 32'hCAFE_F00D;
    for (int i = 0; i < 100 && !cmd_seen; i++) cycle();
    cmd_valid = 1'b0;
    for (int i = 0; i < 50 && !BREADY; i++) cycle();
    chk("t6_in_wr_b", BREADY, 1);
    ref_mem[8'h20 >> 2] = 32'hCAFE_F00D;  // AW and W already reached the slave
    ARESETN = 1'b0;
    #1;
    chk("t6_async_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 6'b0);
    chk("t6_timeout_clr", timeout_err, 0);
    BVALID = 1'b0; b_arm = 0; r_arm = 0; aw_got = 0; w_got = 0; RVALID = 1'b0;
    repeat (2) @(negedge clk);
    ARESETN = 1'b1;
    #1;
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_timeout_after", timeout_err, 0);
    repeat (2) cycle();

    // randomized traffic
    rnd_rdy = 1;
    for (int n = 0; n < 60; n++) begin
      int w;
      w = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7);
      a = 8'(w * 4);
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      bresp_sel = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      rresp_sel = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      run_cmd(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3));
    end

    chk("protocol_violations", prot_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
